// File: rtl/face_pkg.sv
// Shared types and constants for the face display scheduler.
// Face codes, FSM states, segment patterns (active-low, gfedcba).
package face_pkg;

    typedef enum logic [1:0] {
        HAPPY     = 2'b01,
        SAD       = 2'b10,
        SURPRISED = 2'b11
    } face_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam logic [6:0] EYES            = 7'b0011100;
    localparam logic [6:0] MOUTH_HAPPY     = 7'b1100011;
    localparam logic [6:0] MOUTH_SAD       = 7'b0101011;
    localparam logic [6:0] MOUTH_SURPRISED = 7'b0100011;
    localparam logic [6:0] SEG_BLANK       = 7'b1111111;

    function automatic logic [6:0] mouth_of(input face_e f);
        logic [6:0] m;
        case (f)
            SAD:       m = MOUTH_SAD;
            SURPRISED: m = MOUTH_SURPRISED;
            default:   m = MOUTH_HAPPY;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/face_event_fifo.sv
// Small FIFO of pending 2-bit face codes.
// Ports: clk, rst, push/din, pop/dout, flush, full, empty.
module face_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [1:0] din,
    output logic       full,
    output logic       empty,
    output logic [1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rptr];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_do_push)
            r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/face_display_scheduler.sv
// Queues face requests and plays each on the 2-digit display.
// In: clk, rst, newHighScore, levelUp, died, gameHex1/0.
// Out: hex1/0, showFace, busy, dropped.
module face_display_scheduler
    import face_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newHighScore,
    input  logic       levelUp,
    input  logic       died,
    input  logic [6:0] gameHex1,
    input  logic [6:0] gameHex0,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       showFace,
    output logic       busy,
    output logic       dropped
);

    localparam int HG =
        (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int T_MAX = (HG > 2) ? HG : 2;
    localparam int TW    = $clog2(T_MAX);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    face_e         r_face;
    face_e         w_face_nxt;

    logic       w_win_hs;
    logic       w_win_lu;
    logic       w_lose;
    logic       w_push_req;
    logic [1:0] w_req_face;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [1:0] w_dout;
    logic       w_drop;

    logic [6:0] r_hex1;
    logic [6:0] r_hex0;
    logic       r_show;
    logic       r_dropped;
    logic [6:0] w_hex1_nxt;
    logic [6:0] w_hex0_nxt;
    logic       w_show_nxt;

    // Priority died > newHighScore > levelUp; every loser is a drop.
    assign w_win_hs   = newHighScore & ~died;
    assign w_win_lu   = levelUp & ~died & ~newHighScore;
    assign w_lose     = (died & (newHighScore | levelUp))
                      | (newHighScore & levelUp);
    assign w_push_req = w_win_hs | w_win_lu;
    assign w_req_face = w_win_hs ? HAPPY : SURPRISED;
    assign w_drop     = w_lose | (w_push_req & w_full & ~w_pop);

    face_event_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .flush (died),
        .din   (w_req_face),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_face  <= HAPPY;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_face  <= w_face_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_face_nxt  = r_face;
        w_pop       = 1'b0;
        if (died) begin
            // Preempts any state, including a SAD already showing.
            w_state_nxt = SHOW;
            w_timer_nxt = HOLD_LOAD;
            w_face_nxt  = SAD;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = SHOW;
                        w_timer_nxt = HOLD_LOAD;
                        w_face_nxt  = face_e'(w_dout);
                    end
                end
                SHOW: begin
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = GAP;
                        w_timer_nxt = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (r_timer != '0)
                        w_timer_nxt = r_timer - 1'b1;
                    else
                        w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_show_nxt = 1'b0;
        w_hex1_nxt = gameHex1;
        w_hex0_nxt = gameHex0;
        if (r_state == SHOW) begin
            w_show_nxt = 1'b1;
            w_hex1_nxt = EYES;
            w_hex0_nxt = mouth_of(r_face);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex1    <= SEG_BLANK;
            r_hex0    <= SEG_BLANK;
            r_show    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_hex1    <= w_hex1_nxt;
            r_hex0    <= w_hex0_nxt;
            r_show    <= w_show_nxt;
            r_dropped <= w_drop;
        end
    end

    assign hex1     = r_hex1;
    assign hex0     = r_hex0;
    assign showFace = r_show;
    assign dropped  = r_dropped;
    assign busy     = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_face_display_scheduler.sv
// Directed table-driven bench for face_display_scheduler.
// HOLD=8, GAP=2, DEPTH=2; cycle n = n-th edge after reset release.
module tb_face_display_scheduler;

    localparam int NC = 45;

    localparam logic [6:0] X_EYES = 7'b0011100;
    localparam logic [6:0] X_HAP  = 7'b1100011;
    localparam logic [6:0] X_SAD  = 7'b0101011;
    localparam logic [6:0] X_SUR  = 7'b0100011;
    localparam logic [6:0] X_BLK  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nhs = 1'b0;
    logic       lu  = 1'b0;
    logic       died = 1'b0;
    logic [6:0] gh1 = '0;
    logic [6:0] gh0 = '0;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       show;
    logic       busy;
    logic       drop;

    always #5 clk = ~clk;

    face_display_scheduler #(
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (2),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .newHighScore (nhs),
        .levelUp      (lu),
        .died         (died),
        .gameHex1     (gh1),
        .gameHex0     (gh0),
        .hex1         (hex1),
        .hex0         (hex0),
        .showFace     (show),
        .busy         (busy),
        .dropped      (drop)
    );

    // mode: 0 = game digits, 1 = face, 2 = blank (reset)
    typedef struct {
        int         scen;
        int         cyc;
        logic       nhs;
        logic       lu;
        logic       died;
        logic       rst;
    } ev_t;

    typedef struct {
        int         scen;
        int         lo;
        int         hi;
        int         mode;
        logic [6:0] mouth;
        int         busy;
    } win_t;

    ev_t  evs[$];
    win_t wins[$];
    int   drop_at [1:7];

    logic       s_nhs  [0:NC];
    logic       s_lu   [0:NC];
    logic       s_died [0:NC];
    logic       s_rst  [0:NC];
    logic [6:0] o_h1   [0:NC];
    logic [6:0] o_h0   [0:NC];
    logic       o_show [0:NC];
    logic       o_busy [0:NC];
    logic       o_drop [0:NC];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [6:0] gh1f(input int n);
        return 7'((n * 5 + 3) % 128);
    endfunction

    function automatic logic [6:0] gh0f(input int n);
        return 7'((n * 11 + 1) % 128);
    endfunction

    function automatic ev_t mk_ev(input int s, input int c,
        input logic a, input logic b, input logic d, input logic r);
        ev_t e;
        e.scen = s; e.cyc = c;
        e.nhs = a; e.lu = b; e.died = d; e.rst = r;
        return e;
    endfunction

    function automatic win_t mk_w(input int s, input int lo,
        input int hi, input int m, input logic [6:0] mo, input int b);
        win_t w;
        w.scen = s; w.lo = lo; w.hi = hi;
        w.mode = m; w.mouth = mo; w.busy = b;
        return w;
    endfunction

    task automatic run_scen(input int s);
        for (int n = 0; n <= NC; n++) begin
            s_nhs[n] = 0; s_lu[n] = 0; s_died[n] = 0; s_rst[n] = 0;
        end
        foreach (evs[i]) begin
            if (evs[i].scen == s) begin
                s_nhs[evs[i].cyc]  = evs[i].nhs;
                s_lu[evs[i].cyc]   = evs[i].lu;
                s_died[evs[i].cyc] = evs[i].died;
                s_rst[evs[i].cyc]  = evs[i].rst;
            end
        end
        rst = 1; nhs = 0; lu = 0; died = 0;
        gh1 = 7'h2A; gh0 = 7'h15;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (show !== 1'b0 || busy !== 1'b0 || drop !== 1'b0 ||
            hex1 !== X_BLK || hex0 !== X_BLK) begin
            n_fail++;
            $display("FAIL reset s%0d: show=%b busy=%b drop=%b hex=%h/%h, want 0 0 0 7f/7f",
                     s, show, busy, drop, hex1, hex0);
        end
        for (int n = 1; n <= NC; n++) begin
            rst  = s_rst[n];
            nhs  = s_nhs[n];
            lu   = s_lu[n];
            died = s_died[n];
            gh1  = gh1f(n);
            gh0  = gh0f(n);
            @(posedge clk);
            @(negedge clk);
            o_h1[n]   = hex1;
            o_h0[n]   = hex0;
            o_show[n] = show;
            o_busy[n] = busy;
            o_drop[n] = drop;
        end
        rst = 0; nhs = 0; lu = 0; died = 0;
    endtask

    task automatic check_scen(input int s);
        foreach (wins[i]) begin
            if (wins[i].scen == s) begin
                logic bad;
                bad = 0;
                n_chk++;
                for (int n = wins[i].lo; n <= wins[i].hi; n++) begin
                    logic [6:0] e1, e0;
                    logic       es, ed;
                    es = (wins[i].mode == 1);
                    ed = (n == drop_at[s]);
                    case (wins[i].mode)
                        1:       begin e1 = X_EYES; e0 = wins[i].mouth; end
                        2:       begin e1 = X_BLK;  e0 = X_BLK; end
                        default: begin e1 = gh1f(n); e0 = gh0f(n); end
                    endcase
                    if (!bad && (o_show[n] !== es || o_h1[n] !== e1 ||
                        o_h0[n] !== e0 || o_drop[n] !== ed ||
                        (wins[i].busy >= 0 &&
                         o_busy[n] !== wins[i].busy[0]))) begin
                        bad = 1;
                        $display("FAIL window s%0d[%0d..%0d] n=%0d: got show=%b hex=%h/%h drop=%b busy=%b, want show=%b hex=%h/%h drop=%b busy=%0d",
                                 s, wins[i].lo, wins[i].hi, n,
                                 o_show[n], o_h1[n], o_h0[n], o_drop[n],
                                 o_busy[n], es, e1, e0, ed, wins[i].busy);
                    end
                end
                if (bad) n_fail++;
            end
        end
    endtask

    initial begin
        // stimulus: scenario, cycle, newHighScore, levelUp, died, rst
        evs.push_back(mk_ev(2, 10, 1, 0, 0, 0));
        evs.push_back(mk_ev(3, 10, 0, 1, 0, 0));
        evs.push_back(mk_ev(3, 11, 1, 0, 0, 0));
        evs.push_back(mk_ev(4, 10, 0, 1, 0, 0));
        evs.push_back(mk_ev(4, 11, 0, 1, 0, 0));
        evs.push_back(mk_ev(4, 12, 0, 1, 0, 0));
        evs.push_back(mk_ev(4, 13, 0, 1, 0, 0));
        evs.push_back(mk_ev(5, 10, 1, 0, 0, 0));
        evs.push_back(mk_ev(5, 11, 0, 1, 0, 0));
        evs.push_back(mk_ev(5, 15, 0, 0, 1, 0));
        evs.push_back(mk_ev(6, 10, 1, 1, 1, 0));
        evs.push_back(mk_ev(7, 10, 1, 0, 0, 0));
        evs.push_back(mk_ev(7, 14, 0, 0, 0, 1));

        drop_at[1] = 0; drop_at[2] = 0; drop_at[3] = 0;
        drop_at[4] = 13; drop_at[5] = 0; drop_at[6] = 10;
        drop_at[7] = 0;

        // expected: scenario, from, to, mode, mouth, busy (-1 = skip)
        wins.push_back(mk_w(1, 1, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(2, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(2, 10, 11, 0, X_BLK, 1));
        wins.push_back(mk_w(2, 12, 19, 1, X_HAP, 1));
        wins.push_back(mk_w(2, 20, 20, 0, X_BLK, 1));
        wins.push_back(mk_w(2, 21, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(3, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(3, 10, 11, 0, X_BLK, 1));
        wins.push_back(mk_w(3, 12, 19, 1, X_SUR, 1));
        wins.push_back(mk_w(3, 20, 22, 0, X_BLK, 1));
        wins.push_back(mk_w(3, 23, 30, 1, X_HAP, 1));
        wins.push_back(mk_w(3, 31, 31, 0, X_BLK, 1));
        wins.push_back(mk_w(3, 32, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(4, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(4, 10, 11, 0, X_BLK, 1));
        wins.push_back(mk_w(4, 12, 19, 1, X_SUR, 1));
        wins.push_back(mk_w(4, 20, 22, 0, X_BLK, 1));
        wins.push_back(mk_w(4, 23, 30, 1, X_SUR, 1));
        wins.push_back(mk_w(4, 31, 33, 0, X_BLK, 1));
        wins.push_back(mk_w(4, 34, 41, 1, X_SUR, 1));
        wins.push_back(mk_w(4, 42, 42, 0, X_BLK, 1));
        wins.push_back(mk_w(4, 43, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(5, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(5, 10, 11, 0, X_BLK, 1));
        wins.push_back(mk_w(5, 12, 15, 1, X_HAP, 1));
        wins.push_back(mk_w(5, 16, 23, 1, X_SAD, 1));
        wins.push_back(mk_w(5, 24, 24, 0, X_BLK, 1));
        wins.push_back(mk_w(5, 25, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(6, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(6, 10, 10, 0, X_BLK, 1));
        wins.push_back(mk_w(6, 11, 18, 1, X_SAD, 1));
        wins.push_back(mk_w(6, 19, 19, 0, X_BLK, 1));
        wins.push_back(mk_w(6, 20, 45, 0, X_BLK, 0));

        wins.push_back(mk_w(7, 1, 9, 0, X_BLK, 0));
        wins.push_back(mk_w(7, 10, 11, 0, X_BLK, 1));
        wins.push_back(mk_w(7, 12, 13, 1, X_HAP, 1));
        wins.push_back(mk_w(7, 14, 14, 2, X_BLK, 0));
        wins.push_back(mk_w(7, 15, 45, 0, X_BLK, 0));

        for (int s = 1; s <= 7; s++) begin
            run_scen(s);
            check_scen(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
